// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Byte-stream boot loader feeding the instruction memory of the MIPS32 SOC.
// Stream: LEN_HI, LEN_LO (word count N), then 4*N bytes, MSB first per word.
// Words are written to consecutive word addresses starting at 0, and the CPU
// is held in reset until the whole image has landed.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// 8-bit additive checksum byte over all data bytes.
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA    = 3'd3,
    S_CHK     = 3'd4,
    S_RELEASE = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } loaderState;

  // Largest image that fits: exactly 2^ADDR_W words.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  loaderState stateReg;
  loaderState stateNext;

  logic [15:0]     countReg;     // word count N from the header
  logic [ADDR_W:0] wordIdxReg;   // one extra bit so N = 2^ADDR_W is reachable
  logic [1:0]      byteIdxReg;   // byte position within the current word
  logic [23:0]     asmReg;       // first three bytes of the word being built

  logic        xfer;             // byte handshake completes on this edge
  logic        startAccepted;    // start seen in a state that honours it
  logic [15:0] lenIn;            // full length as it is being completed in LEN_LO
  logic        lastByteOfWord;
  logic        lastWord;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sumReg;            // running mod-256 sum of data bytes
`endif

  assign xfer           = rx_valid & rx_ready;
  assign startAccepted  = start & ((stateReg == S_IDLE) || (stateReg == S_DONE) ||
                                   (stateReg == S_ERR));
  assign lenIn          = {countReg[15:8], rx_data};
  assign lastByteOfWord = (byteIdxReg == 2'd3);
  assign lastWord       = ((17'(wordIdxReg) + 17'd1) == {1'b0, countReg});

  // State register; async reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= S_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state decode driven by the byte handshake and start.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      S_IDLE: begin
        if (start) stateNext = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) stateNext = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if ({1'b0, lenIn} > MAX_WORDS) begin
            stateNext = S_ERR;
          end else if (lenIn == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            stateNext = S_CHK;
`else
            stateNext = S_RELEASE;
`endif
          end else begin
            stateNext = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer && lastByteOfWord && lastWord) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          stateNext = S_CHK;
`else
          stateNext = S_RELEASE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) stateNext = (rx_data == sumReg) ? S_RELEASE : S_ERR;
      end
`endif
      // One settle cycle so the final imem write has completed before release.
      S_RELEASE: begin
        stateNext = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (start) stateNext = S_LEN_HI;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state alone, so reset takes effect at once.
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b1;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (stateReg)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: rx_ready = 1'b1;
      default: rx_ready = 1'b0;
    endcase
    case (stateReg)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_DONE: begin
        busy    = 1'b0;
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Header capture, word assembly and the registered imem write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countReg   <= '0;
      wordIdxReg <= '0;
      byteIdxReg <= '0;
      asmReg     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (xfer) begin
        case (stateReg)
          S_LEN_HI: begin
            countReg[15:8] <= rx_data;
          end
          S_LEN_LO: begin
            countReg[7:0] <= rx_data;
            wordIdxReg    <= '0;
            byteIdxReg    <= '0;
          end
          S_DATA: begin
            byteIdxReg <= byteIdxReg + 2'd1;
            asmReg     <= {asmReg[15:0], rx_data};
            if (lastByteOfWord) begin
              imem_we    <= 1'b1;
              imem_addr  <= wordIdxReg[ADDR_W-1:0];
              imem_wdata <= {asmReg, rx_data};
              wordIdxReg <= wordIdxReg + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running checksum: cleared when a new load begins, accumulates data bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sumReg <= '0;
    end else if (startAccepted) begin
      sumReg <= '0;
    end else if (xfer && (stateReg == S_DATA)) begin
      sumReg <= sumReg + rx_data;
    end
  end
`else
  // Without the checksum there is nothing to clear when a load begins.
  logic unusedStart;
  assign unusedStart = startAccepted;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: a per-cycle vector table for the basic
// flows plus hand-written sequences for stalls, reset mid-load, start during
// DATA, the 2^ADDR_W boundary and (when enabled) the checksum.
module tb_imem_boot_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Write monitor: records every imem write with the cycle it was seen in.
  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wrRec;
  wrRec wrQ[$];

  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) wrQ.push_back('{int'(imem_addr), imem_wdata, cycle});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, ".imem_we"}, 32'(imem_we), 32'd0);
    check({tag, ".imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, ".imem_wdata"}, imem_wdata, 32'd0);
    check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".error"}, 32'(error), 32'd0);
  endtask

  // Offer one byte after gap idle cycles; returns #1 after the accepting edge.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL byte_accept: rx_ready stayed %b for byte 0x%02h, expected 1", rx_ready, b);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  logic [31:0] imgWords[$];

  // Send header + data (+ checksum byte when enabled). start is held high
  // while data byte number startAt is being sent.
  task automatic sendImage(input int gap, input int startAt, input bit badSum);
    logic [7:0]  sum;
    logic [15:0] n;
    int          bi;
    sum = 8'h00;
    n   = 16'(imgWords.size());
    bi  = 0;
    sendByte(n[15:8], gap);
    sendByte(n[7:0], gap);
    foreach (imgWords[w]) begin
      for (int k = 3; k >= 0; k--) begin
        logic [7:0] b;
        b = imgWords[w][8*k +: 8];
        sum = sum + b;
        start = (bi == startAt);
        sendByte(b, gap);
        start = 1'b0;
        bi++;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(badSum ? sum + 8'd1 : sum, gap);
`else
    if (badSum) $display("note: checksum disabled, no trailing byte sent");
`endif
    $display("image sent: n=%0d sum=0x%02h gap=%0d", n, sum, gap);
  endtask

  // Called right after the final byte: RELEASE now, DONE one cycle later.
  task automatic expectFinish(input string tag);
    check({tag, ".release_done"}, 32'(done), 32'd0);
    check({tag, ".release_cpu_rst"}, 32'(cpu_rst), 32'd1);
    @(posedge clk);
    #1;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".rx_ready"}, 32'(rx_ready), 32'd0);
  endtask

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        cr;
    logic        bsy;
    logic        dn;
    logic        err;
  } vecRec;
  vecRec vecs[$];

  task automatic addRow(input logic st, input logic vld, input logic [7:0] d,
                        input logic rdy, input logic we, input logic [9:0] addr,
                        input logic [31:0] wd, input logic cr, input logic bsy,
                        input logic dn, input logic err);
    vecs.push_back('{st, vld, d, rdy, we, addr, wd, cr, bsy, dn, err});
  endtask

  initial begin
    int mism;
    string tag;

    // ---------------- vector table ----------------
    // inputs before the edge -> outputs 1 time unit after it
    addRow(1, 0, 8'h00,  1, 0, 0, 32'h0,        1, 1, 0, 0); // IDLE -> LEN_HI
    addRow(0, 1, 8'h00,  1, 0, 0, 32'h0,        1, 1, 0, 0); // -> LEN_LO
    addRow(0, 1, 8'h01,  1, 0, 0, 32'h0,        1, 1, 0, 0); // N=1 -> DATA
    addRow(0, 1, 8'h12,  1, 0, 0, 32'h0,        1, 1, 0, 0);
    addRow(0, 1, 8'h34,  1, 0, 0, 32'h0,        1, 1, 0, 0);
    addRow(0, 1, 8'h56,  1, 0, 0, 32'h0,        1, 1, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    addRow(0, 1, 8'h78,  1, 1, 0, 32'h12345678, 1, 1, 0, 0); // write, -> CHK
    addRow(0, 1, 8'h14,  0, 0, 0, 32'h12345678, 1, 1, 0, 0); // sum ok -> RELEASE
`else
    addRow(0, 1, 8'h78,  0, 1, 0, 32'h12345678, 1, 1, 0, 0); // write, -> RELEASE
`endif
    addRow(0, 0, 8'h00,  0, 0, 0, 32'h12345678, 0, 0, 1, 0); // DONE
    addRow(0, 1, 8'hAA,  0, 0, 0, 32'h12345678, 0, 0, 1, 0); // byte not consumed
    addRow(1, 0, 8'h00,  1, 0, 0, 32'h12345678, 1, 1, 0, 0); // start in DONE
    addRow(0, 1, 8'h04,  1, 0, 0, 32'h12345678, 1, 1, 0, 0);
    addRow(0, 1, 8'h01,  0, 0, 0, 32'h12345678, 1, 0, 0, 1); // 1025 -> ERR
    addRow(0, 1, 8'hFF,  0, 0, 0, 32'h12345678, 1, 0, 0, 1); // stays ERR
    addRow(1, 0, 8'h00,  1, 0, 0, 32'h12345678, 1, 1, 0, 0); // start clears error
    addRow(0, 1, 8'h00,  1, 0, 0, 32'h12345678, 1, 1, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    addRow(0, 1, 8'h00,  1, 0, 0, 32'h12345678, 1, 1, 0, 0); // N=0 -> CHK
    addRow(0, 1, 8'h00,  0, 0, 0, 32'h12345678, 1, 1, 0, 0); // -> RELEASE
`else
    addRow(0, 1, 8'h00,  0, 0, 0, 32'h12345678, 1, 1, 0, 0); // N=0 -> RELEASE
`endif
    addRow(0, 0, 8'h00,  0, 0, 0, 32'h12345678, 0, 0, 1, 0); // DONE

    // ---------------- reset ----------------
    #2 rst = 1'b0;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      start    = vecs[i].st;
      rx_valid = vecs[i].vld;
      rx_data  = vecs[i].d;
      @(posedge clk);
      #1;
      tag = $sformatf("vec%0d", i);
      check({tag, ".rx_ready"}, 32'(rx_ready), 32'(vecs[i].rdy));
      check({tag, ".imem_we"}, 32'(imem_we), 32'(vecs[i].we));
      check({tag, ".imem_addr"}, 32'(imem_addr), 32'(vecs[i].addr));
      check({tag, ".imem_wdata"}, imem_wdata, vecs[i].wd);
      check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(vecs[i].cr));
      check({tag, ".busy"}, 32'(busy), 32'(vecs[i].bsy));
      check({tag, ".done"}, 32'(done), 32'(vecs[i].dn));
      check({tag, ".error"}, 32'(error), 32'(vecs[i].err));
      $display("vec %0d: st=%0b vld=%0b d=%02h -> rdy=%0b we=%0b addr=%0d wd=%08h busy=%0b done=%0b err=%0b",
               i, vecs[i].st, vecs[i].vld, vecs[i].d, rx_ready, imem_we, imem_addr,
               imem_wdata, busy, done, error);
    end
    start    = 1'b0;
    rx_valid = 1'b0;

    // ---------------- N=3 with rx_valid toggling ----------------
    wrQ.delete();
    imgWords = '{32'h11223344, 32'hA5A55A5A, 32'hCAFEF00D};
    pulseStart();
    sendImage(1, -1, 1'b0);
    expectFinish("stall");
    check("stall.writes", 32'(wrQ.size()), 32'd3);
    if (wrQ.size() == 3) begin
      foreach (wrQ[i]) begin
        check($sformatf("stall.addr%0d", i), 32'(wrQ[i].addr), 32'(i));
        check($sformatf("stall.data%0d", i), wrQ[i].data, imgWords[i]);
      end
      check("stall.spacing", 32'(wrQ[1].cyc - wrQ[0].cyc), 32'd8);
    end

    // ---------------- reset mid-load ----------------
    pulseStart();
    sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    sendByte(8'hAB, 0);
    sendByte(8'hCD, 0);
    #2 rst = 1'b0;
    #1;
    checkResetOutputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.idle_busy", 32'(busy), 32'd0);
    check("midrst.idle_ready", 32'(rx_ready), 32'd0);
    wrQ.delete();
    imgWords = '{32'hDEADBEEF};
    pulseStart();
    sendImage(0, -1, 1'b0);
    expectFinish("reload");
    check("reload.writes", 32'(wrQ.size()), 32'd1);
    if (wrQ.size() == 1) begin
      check("reload.addr", 32'(wrQ[0].addr), 32'd0);
      check("reload.data", wrQ[0].data, 32'hDEADBEEF);
    end

    // ---------------- start during DATA, then start in DONE ----------------
    wrQ.delete();
    imgWords = '{32'h01020304, 32'h0A0B0C0D};
    pulseStart();
    sendImage(0, 1, 1'b0);
    expectFinish("startdata");
    check("startdata.writes", 32'(wrQ.size()), 32'd2);
    if (wrQ.size() == 2) begin
      check("startdata.addr1", 32'(wrQ[1].addr), 32'd1);
      check("startdata.data0", wrQ[0].data, 32'h01020304);
      check("startdata.data1", wrQ[1].data, 32'h0A0B0C0D);
    end
    pulseStart();
    check("restart.cpu_rst", 32'(cpu_rst), 32'd1);
    check("restart.done", 32'(done), 32'd0);
    check("restart.rx_ready", 32'(rx_ready), 32'd1);
    imgWords.delete();
    sendImage(0, -1, 1'b0);
    expectFinish("zero");

    // ---------------- N = 2^ADDR_W boundary ----------------
    wrQ.delete();
    imgWords.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) imgWords.push_back(32'h5A000000 | 32'(i * 7));
    pulseStart();
    sendImage(0, -1, 1'b0);
    expectFinish("full");
    check("full.writes", 32'(wrQ.size()), 32'(1 << ADDR_W));
    mism = 0;
    foreach (wrQ[i]) begin
      if (wrQ[i].addr != i || wrQ[i].data !== (32'h5A000000 | 32'(i * 7))) mism++;
    end
    check("full.contents_mismatches", 32'(mism), 32'd0);
    if (wrQ.size() == (1 << ADDR_W)) begin
      check("full.last_addr", 32'(wrQ[(1 << ADDR_W) - 1].addr), 32'((1 << ADDR_W) - 1));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // ---------------- checksum good / bad ----------------
    imgWords = '{32'h01020304};
    pulseStart();
    sendImage(0, -1, 1'b0);
    expectFinish("sumgood");
    pulseStart();
    sendImage(0, -1, 1'b1);
    check("sumbad.error", 32'(error), 32'd1);
    check("sumbad.busy", 32'(busy), 32'd0);
    check("sumbad.cpu_rst", 32'(cpu_rst), 32'd1);
    check("sumbad.done", 32'(done), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
